// File: rtl/icache_pkg.sv
// Shared types, default geometry and helpers for the instruction cache refill path.
package icache_pkg;

    // Refill sequencer states
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE
    } state_e;

    // Default geometry: 4 words of 32 bits per line
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WORD_BITS  = 32;
    localparam int unsigned WORD_BYTES = WORD_BITS / 8;
    localparam int unsigned OFFSET_W   = $clog2(LINE_WORDS * WORD_BYTES);

    // Clear the byte-offset-within-line bits of an address
    function automatic logic [31:0] align_line(input logic [31:0] addr,
                                               input int unsigned offset_w);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_w) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// Line assembly buffer: one word written per beat, whole line presented flat.
module icache_fill_buffer
    import icache_pkg::*;
#(
    parameter int unsigned N_CACHELINE_LENGTH = LINE_WORDS,
    parameter int unsigned BITSIZE            = WORD_BITS,
    localparam int unsigned BEAT_W = (N_CACHELINE_LENGTH > 1) ? $clog2(N_CACHELINE_LENGTH) : 1,
    localparam int unsigned LINE_W = BITSIZE * N_CACHELINE_LENGTH
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [BITSIZE-1:0] wdata_i,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;

    // Store the incoming beat into its word slot; word 0 occupies the low bits
    always_ff @(posedge clk) begin
        if (reset_i) begin
            line_q <= '0;
        end else if (we_i) begin
            line_q[beat_i*BITSIZE +: BITSIZE] <= wdata_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss handler: detects misses, fetches a line beat by beat over a
// req/gnt/rvalid port and writes it into a round-robin victim line.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned N_CACHELINE_LENGTH = LINE_WORDS,
    parameter int unsigned N_CACHELINES       = 8,
    parameter int unsigned BITSIZE            = WORD_BITS
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic                                  cpu_req_i,
    input  logic [31:0]                           cpu_addr_i,
    input  logic [N_CACHELINES-1:0]               hit_vec_i,
    output logic                                  cpu_stall_o,
    output logic [31:0]                           line_addr_o,
    output logic [N_CACHELINES-1:0]               store_o,
    output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o,
    output logic                                  mem_req_o,
    output logic [31:0]                           mem_addr_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [BITSIZE-1:0]                    mem_rdata_i,
    output logic [31:0]                           miss_cnt_o
);

    localparam int unsigned BYTES_PER_WORD = BITSIZE / 8;
    localparam int unsigned LINE_OFFSET_W  = $clog2(N_CACHELINE_LENGTH * BYTES_PER_WORD);
    localparam int unsigned BEAT_W   = (N_CACHELINE_LENGTH > 1) ? $clog2(N_CACHELINE_LENGTH) : 1;
    localparam int unsigned VICTIM_W = (N_CACHELINES > 1) ? $clog2(N_CACHELINES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_CACHELINE_LENGTH - 1);
    localparam logic [N_CACHELINES-1:0] ONE_HOT_0 = N_CACHELINES'(1);

    state_e                  state_q;
    logic [31:0]             miss_addr_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [VICTIM_W-1:0]     victim_q;
    logic [31:0]             miss_cnt_q;
    logic                    mem_req_q;
    logic [N_CACHELINES-1:0] store_q;
    logic                    miss;
    logic                    fill_we;

    assign miss    = cpu_req_i & ~(|hit_vec_i);
    assign fill_we = (state_q == WAIT) & mem_rvalid_i;

    // Refill sequencer with registered request and store strobes
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            beat_q      <= '0;
            victim_q    <= '0;
            miss_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            store_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        miss_addr_q <= align_line(cpu_addr_i, LINE_OFFSET_W);
                        beat_q      <= '0;
                        mem_req_q   <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        if (beat_q == LAST_BEAT) begin
                            store_q <= ONE_HOT_0 << victim_q;
                            state_q <= WRITE;
                        end else begin
                            beat_q    <= beat_q + 1'b1;
                            mem_req_q <= 1'b1;
                            state_q   <= REQ;
                        end
                    end
                end
                WRITE: begin
                    store_q  <= '0;
                    // Power-of-two line count lets the pointer wrap on overflow
                    victim_q <= victim_q + 1'b1;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    icache_fill_buffer #(
        .N_CACHELINE_LENGTH(N_CACHELINE_LENGTH),
        .BITSIZE           (BITSIZE)
    ) u_fill_buffer (
        .clk    (clk),
        .reset_i(reset_i),
        .we_i   (fill_we),
        .beat_i (beat_q),
        .wdata_i(mem_rdata_i),
        .line_o (line_data_o)
    );

    // Lookup address and stall: live CPU address when idle, latched miss line otherwise
    always_comb begin
        line_addr_o = miss_addr_q;
        cpu_stall_o = 1'b1;
        if (state_q == IDLE) begin
            line_addr_o = align_line(cpu_addr_i, LINE_OFFSET_W);
            cpu_stall_o = miss;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = miss_addr_q + 32'(beat_q) * BYTES_PER_WORD;
    assign store_o    = store_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl with a delay-programmable memory.
module tb_icache_refill_ctrl;

    logic         clk;
    logic         reset_i;
    logic         cpu_req_i;
    logic [31:0]  cpu_addr_i;
    logic [7:0]   hit_vec_i;
    logic         cpu_stall_o;
    logic [31:0]  line_addr_o;
    logic [7:0]   store_o;
    logic [127:0] line_data_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic [31:0]  miss_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    icache_refill_ctrl #(
        .N_CACHELINE_LENGTH(4),
        .N_CACHELINES      (8),
        .BITSIZE           (32)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .hit_vec_i   (hit_vec_i),
        .cpu_stall_o (cpu_stall_o),
        .line_addr_o (line_addr_o),
        .store_o     (store_o),
        .line_data_o (line_data_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .miss_cnt_o  (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder state
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [31:0] data_base = 32'h0;
    bit          force_rv  = 1'b0;
    int          gcnt = 0;
    int          rcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] hold_addr = 32'h0;
    int          rv_cnt = 0;
    logic [31:0] gnt_addrs[$];

    // Store monitor
    int           store_cnt  = 0;
    logic [7:0]   last_store = 8'h0;
    logic [127:0] last_line  = '0;
    logic [31:0]  last_laddr = 32'h0;

    // Memory model, evaluated away from the active edge
    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = force_rv;
        mem_rdata_i  = force_rv ? 32'hDEAD_BEEF : 32'h0;
        if (reset_i) begin
            gcnt = 0;
            rcnt = 0;
            pend = 1'b0;
        end else begin
            if (gcnt != 0) begin
                check("req_hold", {127'b0, mem_req_o}, 128'd1);
                check("addr_hold", {96'b0, mem_addr_o}, {96'b0, hold_addr});
            end
            if (mem_req_o) begin
                if (gcnt == 0) hold_addr = mem_addr_o;
                if (gcnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    gnt_addrs.push_back(mem_addr_o);
                    pend      = 1'b1;
                    pend_addr = mem_addr_o;
                    gcnt      = 0;
                    rcnt      = 0;
                end else begin
                    gcnt++;
                end
            end else if (pend) begin
                if (rcnt >= rv_delay) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = data_base + {30'b0, pend_addr[3:2]};
                    pend = 1'b0;
                    rv_cnt++;
                end else begin
                    rcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (store_o != 8'h0) begin
            store_cnt++;
            last_store = store_o;
            last_line  = line_data_o;
            last_laddr = line_addr_o;
        end
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [7:0]  hit;
        logic        exp_stall;
        logic [31:0] exp_laddr;
        logic        exp_mreq;
        logic [7:0]  exp_store;
    } vec_t;

    vec_t vecs[6];

    // Full refill of one line; with use_alt the CPU address moves mid-refill
    task automatic run_miss(input logic [31:0] addr, input logic [31:0] base, input int vict,
                            input int cnt, input int g, input int r,
                            input bit use_alt, input logic [31:0] alt);
        int   stalls;
        bit   seen;
        int   s0;
        logic [31:0] la;
        gnt_delay = g;
        rv_delay  = r;
        data_base = base;
        gnt_addrs.delete();
        s0     = store_cnt;
        stalls = 0;
        seen   = 1'b0;
        la     = addr & 32'hFFFF_FFF0;
        @(posedge clk); #1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = addr;
        hit_vec_i  = 8'h00;
        @(negedge clk);
        check("miss_stall_same_cycle", {127'b0, cpu_stall_o}, 128'd1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (use_alt && cyc == 3) cpu_addr_i = alt;
            if (seen && !use_alt) hit_vec_i = 8'h01 << vict;
            @(negedge clk);
            if (seen) break;
            if (cpu_stall_o) stalls++;
            if (store_o != 8'h0) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL refill_timeout: got no store expected store within 400 cycles");
        end
        check("store_pulses", 128'(store_cnt - s0), 128'd1);
        check("store_onehot", {120'b0, last_store}, {120'b0, 8'h01 << vict});
        check("store_line_addr", {96'b0, last_laddr}, {96'b0, la});
        check("line_data", last_line, {base + 32'd3, base + 32'd2, base + 32'd1, base});
        check("miss_cnt", {96'b0, miss_cnt_o}, 128'(cnt));
        check("stall_cycles", 128'(stalls), 128'(4 * (g + r + 2) + 1));
        check("beats", 128'(gnt_addrs.size()), 128'd4);
        for (int i = 0; i < 4 && i < gnt_addrs.size(); i++)
            check("beat_addr", {96'b0, gnt_addrs[i]}, {96'b0, la + 32'(4 * i)});
        check("mem_req_after_write", {127'b0, mem_req_o}, 128'd0);
        check("store_after_write", {120'b0, store_o}, 128'd0);
        if (use_alt) begin
            check("alt_stall", {127'b0, cpu_stall_o}, 128'd1);
            check("alt_line_addr", {96'b0, line_addr_o}, {96'b0, alt & 32'hFFFF_FFF0});
        end else begin
            check("hit_after_write", {127'b0, cpu_stall_o}, 128'd0);
        end
    endtask

    initial begin
        int s0;
        int rv0;
        bit got;
        reset_i    = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = 32'h0;
        hit_vec_i  = 8'h00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        vecs[0] = '{1'b1, 32'h0000_1234, 8'h04, 1'b0, 32'h0000_1230, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 32'h0000_ABCD, 8'h00, 1'b0, 32'h0000_ABC0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 8'h80, 1'b0, 32'hFFFF_FFF0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 32'h0000_000F, 8'h81, 1'b0, 32'h0000_0000, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 32'h8000_0010, 8'hFF, 1'b0, 32'h8000_0010, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 32'h1234_5678, 8'h00, 1'b0, 32'h1234_5670, 1'b0, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {127'b0, cpu_stall_o}, 128'd0);
        check("rst_mem_req", {127'b0, mem_req_o}, 128'd0);
        check("rst_store", {120'b0, store_o}, 128'd0);
        check("rst_miss_cnt", {96'b0, miss_cnt_o}, 128'd0);
        check("rst_line_data", line_data_o, 128'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Idle lookups: hits and non-requests never leave IDLE
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cpu_req_i  = vecs[i].req;
            cpu_addr_i = vecs[i].addr;
            hit_vec_i  = vecs[i].hit;
            @(negedge clk);
            check("vec_stall", {127'b0, cpu_stall_o}, {127'b0, vecs[i].exp_stall});
            check("vec_line_addr", {96'b0, line_addr_o}, {96'b0, vecs[i].exp_laddr});
            check("vec_mem_req", {127'b0, mem_req_o}, {127'b0, vecs[i].exp_mreq});
            check("vec_store", {120'b0, store_o}, {120'b0, vecs[i].exp_store});
        end
        check("vec_no_refill", {96'b0, miss_cnt_o}, 128'd0);

        // Zero-wait miss, then eight more for the victim wrap
        run_miss(32'h0000_1234, 32'h0000_00A0, 0, 1, 0, 0, 1'b0, 32'h0);
        for (int k = 1; k < 9; k++)
            run_miss(32'h0001_0000 + 32'(k * 16), 32'hB000_0000 + 32'(k * 16), k % 8, k + 1,
                     0, 0, 1'b0, 32'h0);

        // Backpressure on both grant and read data
        run_miss(32'h0000_3038, 32'h5555_0000, 1, 10, 3, 5, 1'b0, 32'h0);

        // CPU address moves during the refill; the latched line completes first
        run_miss(32'h0000_1230, 32'h0000_7700, 2, 11, 0, 0, 1'b1, 32'h0000_2000);
        gnt_addrs.delete();
        data_base = 32'h0000_2200;
        s0  = store_cnt;
        got = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(negedge clk);
            if (store_cnt != s0) got = 1'b1;
        end
        check("alt_refill_done", {127'b0, got}, 128'd1);
        check("alt_first_beat", {96'b0, (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'h0},
              {96'b0, 32'h0000_2000});
        check("alt_store_addr", {96'b0, last_laddr}, {96'b0, 32'h0000_2000});
        check("alt_store_victim", {120'b0, last_store}, {120'b0, 8'h08});
        @(posedge clk); #1;
        hit_vec_i = 8'h08;

        // Reset after three beats of a refill
        gnt_delay = 0;
        rv_delay  = 0;
        data_base = 32'h0000_9900;
        rv0 = rv_cnt;
        s0  = store_cnt;
        @(posedge clk); #1;
        cpu_addr_i = 32'h0000_4000;
        hit_vec_i  = 8'h00;
        got = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(negedge clk);
            if (rv_cnt - rv0 >= 3) got = 1'b1;
        end
        check("partial_beats", {127'b0, got}, 128'd1);
        @(posedge clk); #1;
        reset_i   = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk); #1;
        reset_i  = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_req", {127'b0, mem_req_o}, 128'd0);
        check("mid_rst_stall", {127'b0, cpu_stall_o}, 128'd0);
        check("mid_rst_store", {120'b0, store_o}, 128'd0);
        @(posedge clk); #1;
        force_rv = 1'b0;
        @(negedge clk);
        check("late_rvalid_ignored", {127'b0, mem_req_o}, 128'd0);
        check("mid_rst_no_store", 128'(store_cnt - s0), 128'd0);
        check("mid_rst_miss_cnt", {96'b0, miss_cnt_o}, 128'd0);
        run_miss(32'h0000_5004, 32'h0000_00C0, 0, 1, 0, 0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
